// File: rtl/score_pkg.sv
// Shared types and constants for the score digit scheduler and its BCD converter.
package score_pkg;

  localparam int GLYPH_W       = 16;
  localparam int GLYPH_H       = 16;
  localparam int ROM_ADDR_W    = 12;
  localparam int FRAME_BOUND_Y = 480;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    WAIT_FRAME
  } sched_state_t;

endpackage

// File: rtl/score_bin2bcd.sv
// Sequential double-dabble: one shift per cycle, SCORE_W cycles after start_i.
// overflow_o flags values that do not fit in NUM_DIGITS decimal digits.
module score_bin2bcd
  import score_pkg::*;
#(
  parameter int SCORE_W    = 14,
  parameter int NUM_DIGITS = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [SCORE_W-1:0] value_i,
  output logic               done_o,
  output bcd_t               bcd_o [NUM_DIGITS],
  output logic               overflow_o
);

  localparam int          CNT_W   = $clog2(SCORE_W + 1);
  localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);

  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d, adj;
  logic [SCORE_W-1:0]      bin_q, bin_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    running_q, running_d;
  logic                    ovf_q, ovf_d;

  always_comb begin
    bcd_d     = bcd_q;
    bin_d     = bin_q;
    cnt_d     = cnt_q;
    running_d = running_q;
    ovf_d     = ovf_q;
    adj       = bcd_q;
    if (start_i) begin
      bin_d     = value_i;
      bcd_d     = '0;
      cnt_d     = CNT_W'(SCORE_W);
      running_d = 1'b1;
      ovf_d     = (64'(value_i) > MAX_VAL);
    end else if (running_q) begin
      // Add-3 correction on every digit >= 5 before shifting in the next bit.
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
      end
      {bcd_d, bin_d} = {adj, bin_q} << 1;
      cnt_d          = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) running_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcd_q     <= '0;
      bin_q     <= '0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      bcd_q     <= bcd_d;
      bin_q     <= bin_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      ovf_q     <= ovf_d;
    end
  end

  assign done_o     = running_q && (cnt_q == CNT_W'(1));
  assign overflow_o = ovf_q;

  always_comb begin
    for (int k = 0; k < NUM_DIGITS; k++) bcd_o[k] = bcd_q[4*k +: 4];
  end

endmodule

// File: rtl/score_digit_scheduler.sv
// Draws NUM_DIGITS score digits from one shared glyph ROM; new digits commit only at the frame boundary.
// Optional macro SCORE_LEADING_ZERO_BLANK_EN hides leading-zero cells (least-significant cell always drawn).
module score_digit_scheduler
  import score_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int SCORE_W     = 14,
  parameter int ORIGIN_X    = 16,
  parameter int ORIGIN_Y    = 16,
  parameter int SCALE_SHIFT = 1
) (
  input  logic                  vga_clk,
  input  logic                  reset_n,
  input  logic [SCORE_W-1:0]    score_in,
  input  logic                  score_load,
  input  logic [9:0]            DrawX,
  input  logic [9:0]            DrawY,
  input  logic                  blank,
  output logic [ROM_ADDR_W-1:0] rom_address,
  input  logic [3:0]            rom_q,
  output logic [3:0]            pix_idx,
  output logic                  pix_valid,
  output logic                  busy
);

  localparam int CELL_SHIFT = $clog2(GLYPH_W) + SCALE_SHIFT;
  localparam int CELL_H     = GLYPH_H << SCALE_SHIFT;

  sched_state_t       state_q;
  logic               pendFlag_q;
  logic [SCORE_W-1:0] pendValue_q;
  bcd_t               shown_q [NUM_DIGITS];
  logic [3:0]         pixIdx_q;
  logic               pixValid_q;

  logic frameBound, start, convDone, convOvf;
  bcd_t convBcd [NUM_DIGITS];

  assign frameBound = (DrawX == 10'd0) && (DrawY == 10'(FRAME_BOUND_Y));
  assign start      = pendFlag_q && ((state_q == IDLE) || ((state_q == WAIT_FRAME) && frameBound));

  score_bin2bcd #(.SCORE_W(SCORE_W), .NUM_DIGITS(NUM_DIGITS)) u_bin2bcd (
    .clk_i      (vga_clk),
    .rst_ni     (reset_n),
    .start_i    (start),
    .value_i    (pendValue_q),
    .done_o     (convDone),
    .bcd_o      (convBcd),
    .overflow_o (convOvf)
  );

  // A load arriving in the same cycle as a start keeps the flag set, so the latest value is converted next.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      pendFlag_q  <= 1'b0;
      pendValue_q <= '0;
      for (int i = 0; i < NUM_DIGITS; i++) shown_q[i] <= '0;
    end else begin
      if (score_load) begin
        pendFlag_q  <= 1'b1;
        pendValue_q <= score_in;
      end else if (start) begin
        pendFlag_q  <= 1'b0;
      end
      case (state_q)
        IDLE:       if (pendFlag_q) state_q <= CONV;
        CONV:       if (convDone) state_q <= WAIT_FRAME;
        WAIT_FRAME: if (frameBound) begin
          for (int i = 0; i < NUM_DIGITS; i++)
            shown_q[i] <= convOvf ? bcd_t'(4'd9) : convBcd[NUM_DIGITS-1-i];
          state_q <= pendFlag_q ? CONV : IDLE;
        end
        default:    state_q <= IDLE;
      endcase
    end
  end

  logic [10:0]           rx, ry, cellIdx;
  logic [3:0]            gx, gy;
  logic                  hit, cellVis;
  bcd_t                  glyph;
  logic [NUM_DIGITS-1:0] visMask;

  assign rx      = {1'b0, DrawX} - 11'(ORIGIN_X);
  assign ry      = {1'b0, DrawY} - 11'(ORIGIN_Y);
  assign cellIdx = rx >> CELL_SHIFT;
  assign gx      = 4'(rx >> SCALE_SHIFT);
  assign gy      = 4'(ry >> SCALE_SHIFT);
  assign hit     = !rx[10] && !ry[10] && (ry < 11'(CELL_H)) && (cellIdx < 11'(NUM_DIGITS));

`ifdef SCORE_LEADING_ZERO_BLANK_EN
  logic seenNonZero;
  always_comb begin
    seenNonZero = 1'b0;
    visMask     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      seenNonZero = seenNonZero | (shown_q[i] != 4'd0);
      visMask[i]  = seenNonZero | (i == NUM_DIGITS - 1);
    end
  end
`else
  assign visMask = '1;
`endif

  always_comb begin
    glyph   = '0;
    cellVis = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (cellIdx == 11'(i)) begin
        glyph   = shown_q[i];
        cellVis = visMask[i];
      end
    end
  end

  assign rom_address = hit ? {glyph, gy, gx} : '0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      pixIdx_q   <= '0;
      pixValid_q <= 1'b0;
    end else begin
      pixIdx_q   <= rom_q;
      pixValid_q <= hit & cellVis & blank;
    end
  end

  assign pix_idx   = pixIdx_q;
  assign pix_valid = pixValid_q;
  assign busy      = (state_q != IDLE) | pendFlag_q;

endmodule

// File: tb/tb_score_digit_scheduler.sv
// Directed bench for score_digit_scheduler with a behavioural glyph ROM read on the falling edge.
module tb_score_digit_scheduler;

  localparam int ORIGIN_X = 16;
  localparam int ORIGIN_Y = 16;

  logic        vga_clk;
  logic        reset_n;
  logic [13:0] score_in;
  logic        score_load;
  logic [9:0]  DrawX, DrawY;
  logic        blank;
  logic [11:0] rom_address;
  logic [3:0]  rom_q;
  logic [3:0]  pix_idx;
  logic        pix_valid;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;

  score_digit_scheduler #(
    .NUM_DIGITS(4), .SCORE_W(14), .ORIGIN_X(ORIGIN_X), .ORIGIN_Y(ORIGIN_Y), .SCALE_SHIFT(1)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .score_in    (score_in),
    .score_load  (score_load),
    .DrawX       (DrawX),
    .DrawY       (DrawY),
    .blank       (blank),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .pix_idx     (pix_idx),
    .pix_valid   (pix_valid),
    .busy        (busy)
  );

  initial vga_clk = 1'b0;
  always #5 vga_clk = ~vga_clk;

  function automatic logic [3:0] romModel(input logic [11:0] a);
    return a[3:0] ^ a[7:4] ^ a[11:8];
  endfunction

  initial rom_q = 4'd0;
  always @(negedge vga_clk) rom_q <= romModel(rom_address);

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge vga_clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input int x, input int y, input logic b);
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic loadScore(input int value);
    score_in   = 14'(value);
    score_load = 1'b1;
    tick(1);
    score_load = 1'b0;
  endtask

  task automatic frameBoundary();
    applyStimulus(0, 480, 1'b0);
    tick(1);
    applyStimulus(700, 300, 1'b0);
  endtask

  // Top-left pixel of each cell has gx=gy=0, so the address is just glyph*256.
  task automatic checkDigits(input string tag, input int d0, input int d1, input int d2, input int d3);
    int expd [4];
    expd = '{d0, d1, d2, d3};
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ORIGIN_X + 32 * i, ORIGIN_Y, 1'b0);
      #1;
      checkOutput($sformatf("%s_cell%0d", tag, i), 32'(rom_address), 32'(expd[i] * 256));
    end
    applyStimulus(700, 300, 1'b0);
  endtask

  initial begin
    int lzValid;
    reset_n    = 1'b1;
    score_in   = '0;
    score_load = 1'b0;
    applyStimulus(700, 300, 1'b0);
    #2 reset_n = 1'b0;
    tick(2);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_valid", 32'(pix_valid), 32'd0);
    checkOutput("reset_idx", 32'(pix_idx), 32'd0);
    reset_n = 1'b1;
    tick(2);
    checkDigits("reset_digits", 0, 0, 0, 0);

    $display("[TB] score 42 commit");
    loadScore(42);
    checkOutput("busy_after_load", 32'(busy), 32'd1);
    tick(20);
    checkOutput("busy_wait_frame", 32'(busy), 32'd1);
    checkDigits("pre_boundary", 0, 0, 0, 0);
    frameBoundary();
    checkDigits("digits_42", 0, 0, 4, 2);
    checkOutput("busy_after_commit", 32'(busy), 32'd0);

    $display("[TB] pixel path and boundaries");
    applyStimulus(ORIGIN_X + 64, ORIGIN_Y, 1'b1);
    #1 checkOutput("addr_cell2", 32'(rom_address), 32'd1024);
    tick(1);
    checkOutput("valid_cell2", 32'(pix_valid), 32'd1);
    checkOutput("idx_cell2", 32'(pix_idx), 32'd4);

    applyStimulus(ORIGIN_X + 127, ORIGIN_Y + 31, 1'b1);
    #1 checkOutput("addr_last_px", 32'(rom_address), 32'd767);
    tick(1);
    checkOutput("valid_last_px", 32'(pix_valid), 32'd1);
    checkOutput("idx_last_px", 32'(pix_idx), 32'd2);

    applyStimulus(ORIGIN_X + 128, ORIGIN_Y, 1'b1);
    #1 checkOutput("addr_right_miss", 32'(rom_address), 32'd0);
    tick(1);
    checkOutput("valid_right_miss", 32'(pix_valid), 32'd0);
    checkOutput("idx_right_miss", 32'(pix_idx), 32'd0);

    applyStimulus(ORIGIN_X - 1, ORIGIN_Y, 1'b1);
    #1 checkOutput("addr_left_miss", 32'(rom_address), 32'd0);
    tick(1);
    checkOutput("valid_left_miss", 32'(pix_valid), 32'd0);

    applyStimulus(ORIGIN_X + 64, ORIGIN_Y + 32, 1'b1);
    tick(1);
    checkOutput("valid_below_miss", 32'(pix_valid), 32'd0);

    applyStimulus(ORIGIN_X + 64, ORIGIN_Y - 1, 1'b1);
    tick(1);
    checkOutput("valid_above_miss", 32'(pix_valid), 32'd0);

    applyStimulus(ORIGIN_X + 64, ORIGIN_Y, 1'b0);
    tick(1);
    checkOutput("valid_blanked", 32'(pix_valid), 32'd0);

`ifdef SCORE_LEADING_ZERO_BLANK_EN
    lzValid = 0;
`else
    lzValid = 1;
`endif
    applyStimulus(ORIGIN_X, ORIGIN_Y, 1'b1);
    tick(1);
    checkOutput("valid_lead_cell0", 32'(pix_valid), 32'(lzValid));
    applyStimulus(ORIGIN_X + 32, ORIGIN_Y, 1'b1);
    tick(1);
    checkOutput("valid_lead_cell1", 32'(pix_valid), 32'(lzValid));
    applyStimulus(700, 300, 1'b0);

    $display("[TB] back-to-back loads 100 then 7");
    loadScore(100);
    tick(1);
    loadScore(7);
    tick(20);
    checkOutput("b2b_busy_first", 32'(busy), 32'd1);
    frameBoundary();
    checkDigits("b2b_first", 0, 1, 0, 0);
    checkOutput("b2b_busy_between", 32'(busy), 32'd1);
    tick(20);
    checkOutput("b2b_busy_second", 32'(busy), 32'd1);
    frameBoundary();
    checkDigits("b2b_final", 0, 0, 0, 7);
    checkOutput("b2b_busy_done", 32'(busy), 32'd0);

    $display("[TB] saturation 12000");
    loadScore(12000);
    tick(20);
    frameBoundary();
    checkDigits("saturate", 9, 9, 9, 9);

    $display("[TB] reset during conversion");
    loadScore(1234);
    tick(4);
    reset_n = 1'b0;
    #1;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_valid", 32'(pix_valid), 32'd0);
    tick(2);
    reset_n = 1'b1;
    checkDigits("abort_cleared", 0, 0, 0, 0);
    tick(20);
    checkOutput("abort_busy_idle", 32'(busy), 32'd0);
    frameBoundary();
    checkDigits("abort_no_commit", 0, 0, 0, 0);

    $display("[TB] score 0 visibility");
    loadScore(0);
    tick(20);
    frameBoundary();
    // Pixel (+5,+3) inside any cell: gx=2, gy=1, glyph 0 -> address 18.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(ORIGIN_X + 32 * i + 5, ORIGIN_Y + 3, 1'b1);
      #1 checkOutput($sformatf("zero_addr_cell%0d", i), 32'(rom_address), 32'd18);
      tick(1);
      checkOutput($sformatf("zero_valid_cell%0d", i), 32'(pix_valid), (i == 3) ? 32'd1 : 32'(lzValid));
      checkOutput($sformatf("zero_idx_cell%0d", i), 32'(pix_idx), 32'(romModel(12'd18)));
    end
    applyStimulus(700, 300, 1'b0);
    tick(1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/score_digit_scheduler.md
Name: score_digit_scheduler

Overview:
- Shares one digit-sprite ROM (glyphs 0-9, each 16x16, 4-bit palette index) among NUM_DIGITS on-screen score positions.
- Converts the binary score to BCD sequentially, commits the new digits only at frame boundaries (no tearing), and generates the per-pixel ROM address.
- Returns a registered palette index plus a valid flag to the pixel mux that sits ahead of the palette/colour stage.

Parameters:
NUM_DIGITS, 4, number of decimal digit cells drawn left to right, most-significant digit first
SCORE_W, 14, width of binary score input
ORIGIN_X, 16, screen X of left edge of the most-significant digit cell
ORIGIN_Y, 16, screen Y of top edge of the digit row
SCALE_SHIFT, 1, glyph magnification is 2^SCALE_SHIFT; cell size = 16<<SCALE_SHIFT

Ports:
vga_clk  in  1  pixel clock; ROM is read on its falling edge
reset_n  in  1  asynchronous active-low reset
score_in  in  SCORE_W  binary score
score_load  in  1  one-cycle pulse; sample score_in
DrawX  in  10  current pixel column
DrawY  in  10  current pixel row
blank  in  1  1 = active video
rom_address  out  12  shared digit ROM address = glyph*256 + gy*16 + gx
rom_q  in  4  ROM data, valid before next rising edge
pix_idx  out  4  palette index for the current pixel
pix_valid  out  1  1 = pixel belongs to a digit cell and is drawn
busy  out  1  1 while a conversion is pending or running

Behaviour:
- Reset (async, reset_n=0): all shown digits = 0; pix_idx = 0; pix_valid = 0; busy = 0; FSM = IDLE; pending flag cleared. Reset asserted mid-conversion aborts it, with no partial commit.
- score_load: latches score_in into pend_reg and sets the pending flag. A load during CONV or WAIT_FRAME overwrites pend_reg; latest value wins.
- FSM:
  - IDLE: on pending, clear the flag, then go to CONV.
  - CONV: double-dabble, exactly SCORE_W cycles, one shift per cycle, then go to WAIT_FRAME.
  - WAIT_FRAME: at the frame boundary (DrawX==0 && DrawY==480), copy the BCD result into the shown digits. Then go to CONV if pending, else to IDLE.
- busy = (state!=IDLE) | pending.
- Saturation: if the latched value > 10^NUM_DIGITS - 1, all digits commit as 9.
- Cell hit test:
  - rx = DrawX - ORIGIN_X; ry = DrawY - ORIGIN_Y, computed 11-bit signed. Negative means a miss.
  - cell = rx >> (4+SCALE_SHIFT).
  - hit = ry within [0, 16<<SCALE_SHIFT) and cell < NUM_DIGITS.
  - gx = (rx >> SCALE_SHIFT) & 15; gy = (ry >> SCALE_SHIFT) & 15.
  - glyph = shown digit of that cell.
  - rom_address is combinational from DrawX/DrawY and the shown digits; it is 0 on a miss.
- Output pipeline: on posedge vga_clk, pix_idx <= rom_q and pix_valid <= hit & blank. Both are computed from the same DrawX/DrawY that produced rom_address, giving one-cycle latency.
- pix_valid=0 forces downstream to its background colour. pix_idx is don't-care, but the bench may check it.
- Commit and pixel read in the same cycle: the commit happens at the frame boundary (blank=0), so no visible pixel ever mixes old and new digits.

Optional Feature:
- Macro: SCORE_LEADING_ZERO_BLANK_EN.
- Defined: a digit cell above the most-significant nonzero digit gets pix_valid=0. The least-significant cell is always drawn, so score 0 shows "0".
- Undefined: all NUM_DIGITS cells are drawn with leading zeros, e.g. "0042".

Decomposition:
- Package score_pkg holds:
  - GLYPH_W=16, GLYPH_H=16, ROM_ADDR_W=12, FRAME_BOUND_Y=480
  - typedef bcd_t (logic [3:0])
  - enum sched_state_t {IDLE, CONV, WAIT_FRAME}
- Sub-module score_bin2bcd: sequential double-dabble.
  - start/done handshake.
  - Parameters SCORE_W and NUM_DIGITS.
  - Outputs a bcd_t array plus an overflow flag, which feeds saturation.

Test Plan:
- Reset mid-CONV (score 1234 loaded, reset_n low at cycle 5) -> busy=0 and shown digits 0000 after release; no commit at the next frame boundary.
- score_load 42, run to frame boundary -> digits 0,0,4,2 committed at DrawX=0/DrawY=480, not earlier. Pixel (ORIGIN_X+64, ORIGIN_Y) -> rom_address=4*256=1024. pix_valid=1 one cycle later with pix_idx = rom_q.
- Back-to-back loads 100 then 7 within 3 cycles -> final committed digits 0007; busy stays 1 until that commit.
- score_load 12000 (NUM_DIGITS=4) -> digits 9999.
- Boundaries (SCALE_SHIFT=1):
  - DrawX=ORIGIN_X-1 -> pix_valid=0.
  - DrawX=ORIGIN_X+127 -> cell 3, gx 15.
  - DrawX=ORIGIN_X+128 -> miss.
  - blank=0 inside a cell -> pix_valid=0.
- With SCORE_LEADING_ZERO_BLANK_EN, score 0 -> only cell 3 has pix_valid=1. Without the macro, all four cells are valid and show glyph 0.
